// File: rtl/nn_pkg.sv
// Shared widths, sequencer state encoding and output saturation for the neuron datapath.
package nn_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC_W = 8;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_ADDR_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    ACT,
    DONE
  } state_t;

  localparam logic signed [DEF_ACC_W-1:0] SAT_MAX = DEF_ACC_W'((1 << (DEF_DATA_W - 1)) - 1);
  localparam logic signed [DEF_ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // Clamp a rescaled accumulator into the signed DATA_W output range.
  function automatic logic signed [DEF_DATA_W-1:0] saturate(input logic signed [DEF_ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[DEF_DATA_W-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[DEF_DATA_W-1:0];
    end
    return v[DEF_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/nn_neuron_seq_if.sv
// Software PIO handshake plus the shared read port to the input and weight memories.
interface nn_neuron_seq_if
  import nn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic                     ready_in;
  logic [ADDR_W-1:0]        len;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_rd;
  logic signed [DATA_W-1:0] in_data;
  logic signed [DATA_W-1:0] wt_data;
  logic signed [DATA_W-1:0] result;
  logic                     done;
  logic                     busy;

  modport master (
    input  ready_in, len, in_data, wt_data,
    output mem_addr, mem_rd, result, done, busy
  );

  modport slave (
    output ready_in, len, in_data, wt_data,
    input  mem_addr, mem_rd, result, done, busy
  );

endinterface

// File: rtl/nn_mac.sv
// Signed multiply-accumulate: full-width product sign-extended into the accumulator.
module nn_mac
  import nn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] product;
  logic signed [ACC_W-1:0]    product_ext;

  assign product     = a * b;
  assign product_ext = {{(ACC_W - 2*DATA_W){product[2*DATA_W-1]}}, product};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + product_ext;
    end
  end

endmodule

// File: rtl/nn_neuron_seq.sv
// One-neuron sequencer: fetch LEN input/weight pairs, accumulate, rescale, saturate.
// Define NN_RELU_EN to clamp negative outputs to zero; otherwise the output is signed linear.
module nn_neuron_seq
  import nn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic             clk,
  input logic             reset,
  nn_neuron_seq_if.master bus
);

  state_t                   state;
  logic                     ready_q;
  logic                     rd_q;
  logic                     start;
  logic                     mac_clr;
  logic [ADDR_W-1:0]        len_r;
  logic [ADDR_W-1:0]        addr_r;
  logic                     rd_r;
  logic                     done_r;
  logic                     busy_r;
  logic signed [DATA_W-1:0] result_r;
  logic signed [DATA_W-1:0] sat_val;
  logic signed [DATA_W-1:0] act_val;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  shifted;

  assign start   = bus.ready_in & ~ready_q;
  assign mac_clr = (state == IDLE) && start;

  nn_mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .clr  (mac_clr),
    .en   (rd_q),
    .a    (bus.in_data),
    .b    (bus.wt_data),
    .acc  (acc)
  );

  assign shifted = acc >>> FRAC_W;
  assign sat_val = saturate(shifted);

  always_comb begin
    act_val = sat_val;
`ifdef NN_RELU_EN
    if (sat_val[DATA_W-1]) begin
      act_val = '0;
    end
`endif
  end

  // rd_q tracks the one-cycle memory latency so the MAC only sees valid readdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ready_q  <= 1'b0;
      rd_q     <= 1'b0;
      len_r    <= '0;
      addr_r   <= '0;
      rd_r     <= 1'b0;
      result_r <= '0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      ready_q <= bus.ready_in;
      rd_q    <= rd_r;
      case (state)
        IDLE: begin
          if (start) begin
            len_r  <= bus.len;
            addr_r <= '0;
            busy_r <= 1'b1;
            if (bus.len == '0) begin
              state <= ACT;
            end else begin
              rd_r  <= 1'b1;
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          if (addr_r == len_r - ADDR_W'(1)) begin
            rd_r  <= 1'b0;
            state <= DRAIN;
          end else begin
            addr_r <= addr_r + ADDR_W'(1);
          end
        end
        DRAIN: state <= ACT;
        ACT: begin
          result_r <= act_val;
          busy_r   <= 1'b0;
          done_r   <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          if (!bus.ready_in) begin
            done_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr = addr_r;
  assign bus.mem_rd   = rd_r;
  assign bus.result   = result_r;
  assign bus.done     = done_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_nn_neuron_seq.sv
// Directed bench for nn_neuron_seq with a per-cycle behavioural model and literal spot checks.
module tb_nn_neuron_seq;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   model_live = 1'b0;

  logic [15:0] in_mem [1024];
  logic [15:0] wt_mem [1024];

  nn_neuron_seq_if bus ();

  nn_neuron_seq dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Synchronous memories; junk appears whenever no read was issued.
  always @(posedge clk) begin
    if (bus.mem_rd) begin
      bus.in_data <= in_mem[bus.mem_addr];
      bus.wt_data <= wt_mem[bus.mem_addr];
    end else begin
      bus.in_data <= 16'($urandom);
      bus.wt_data <= 16'($urandom);
    end
  end

  function automatic void check_output(string name, logic [31:0] actual, logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    end
  endfunction

  function automatic logic [15:0] neuron_expect(int n);
    longint sum = 0;
    longint sh;
    for (int i = 0; i < n; i++) begin
      sum += longint'($signed(in_mem[i])) * longint'($signed(wt_mem[i]));
    end
    sh = sum >>> 8;
    if (sh > 32767) sh = 32767;
    if (sh < -32768) sh = -32768;
`ifdef NN_RELU_EN
    if (sh < 0) sh = 0;
`endif
    return 16'(sh);
  endfunction

  // Timeline model: a run lasts len+2 edges (1 edge if len==0), reads issued on the first len edges.
  bit          m_busy, m_done, m_prev, m_start;
  logic [15:0] m_result, m_pending;
  int          m_cnt, m_fetch, m_len;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_prev = 0; m_result = '0;
      m_cnt = 0; m_fetch = 0; m_len = 0;
    end else begin
      m_start = bus.ready_in && !m_prev;
      m_prev  = bus.ready_in;
      if (m_done) begin
        if (!bus.ready_in) m_done = 0;
      end else if (m_busy) begin
        m_fetch++;
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0;
          m_done = 1;
          m_result = m_pending;
        end
      end else if (m_start) begin
        m_len     = int'(bus.len);
        m_pending = neuron_expect(m_len);
        m_busy    = 1;
        m_fetch   = 0;
        m_cnt     = (m_len == 0) ? 1 : m_len + 2;
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check_output("done", bus.done, m_done);
      check_output("busy", bus.busy, m_busy);
      check_output("result", $unsigned(bus.result), m_result);
      check_output("mem_rd", bus.mem_rd, m_busy && (m_fetch < m_len));
      if (m_busy && (m_fetch < m_len)) check_output("mem_addr", bus.mem_addr, m_fetch);
    end
  end

  int lat, rd_seen, addr_bad;

  task automatic apply_stimulus(input int n);
    @(negedge clk);
    bus.len = n[9:0];
    bus.ready_in = 1'b1;
    lat = 0; rd_seen = 0; addr_bad = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.mem_rd) begin
        if (bus.mem_addr != 10'(rd_seen)) addr_bad++;
        rd_seen++;
      end
      if (bus.done) break;
    end
    check_output("done_within_bound", bus.done, 1);
  endtask

  task automatic drop_ready();
    @(negedge clk);
    bus.ready_in = 1'b0;
    @(posedge clk); #1;
    check_output("done_clear", bus.done, 0);
  endtask

  initial begin
    int extra_rd;
    bit hit;
    bus.ready_in = 1'b0;
    bus.len = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_addr", bus.mem_addr, 0);
    check_output("rst_rd", bus.mem_rd, 0);
    check_output("rst_result", $unsigned(bus.result), 0);
    check_output("rst_done", bus.done, 0);
    check_output("rst_busy", bus.busy, 0);
    model_live = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] len=0 run and held-ready handshake");
    apply_stimulus(0);
    check_output("len0_latency", lat, 2);
    check_output("len0_reads", rd_seen, 0);
    check_output("len0_result", $unsigned(bus.result), 16'h0000);
    extra_rd = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.mem_rd || bus.busy) extra_rd++;
    end
    check_output("hold_done", bus.done, 1);
    check_output("hold_no_rerun", extra_rd, 0);
    drop_ready();

    $display("[TB] basic dot product");
    in_mem[0] = 16'h0100; in_mem[1] = 16'h0200; in_mem[2] = 16'h0300;
    wt_mem[0] = 16'h0080; wt_mem[1] = 16'h0080; wt_mem[2] = 16'h0080;
    apply_stimulus(3);
    check_output("basic_result", $unsigned(bus.result), 16'h0300);
    check_output("basic_latency", lat, 6);
    check_output("basic_reads", rd_seen, 3);
    check_output("basic_addr_seq", addr_bad, 0);
    drop_ready();

    $display("[TB] negative sum");
    in_mem[0] = 16'h0100; in_mem[1] = 16'h0100;
    wt_mem[0] = 16'hFF00; wt_mem[1] = 16'hFF00;
    apply_stimulus(2);
`ifdef NN_RELU_EN
    check_output("neg_result", $unsigned(bus.result), 16'h0000);
`else
    check_output("neg_result", $unsigned(bus.result), 16'hFE00);
`endif
    check_output("neg_latency", lat, 5);
    drop_ready();

    $display("[TB] saturation");
    for (int i = 0; i < 4; i++) begin
      in_mem[i] = 16'h7FFF;
      wt_mem[i] = 16'h7FFF;
    end
    apply_stimulus(4);
    check_output("sat_pos", $unsigned(bus.result), 16'h7FFF);
    check_output("sat_latency", lat, 7);
    drop_ready();
    for (int i = 0; i < 4; i++) wt_mem[i] = 16'h8000;
    apply_stimulus(4);
`ifdef NN_RELU_EN
    check_output("sat_neg", $unsigned(bus.result), 16'h0000);
`else
    check_output("sat_neg", $unsigned(bus.result), 16'h8000);
`endif
    drop_ready();

    $display("[TB] reset in the middle of a fetch");
    for (int i = 0; i < 10; i++) begin
      in_mem[i] = 16'((i + 1) * 256);
      wt_mem[i] = 16'h0040;
    end
    @(negedge clk);
    bus.len = 10'd10;
    bus.ready_in = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (bus.mem_rd && bus.mem_addr == 10'd5) begin
        hit = 1'b1;
        break;
      end
    end
    check_output("reached_addr5", hit, 1);
    reset = 1'b1;
    #1;
    check_output("midrst_addr", bus.mem_addr, 0);
    check_output("midrst_rd", bus.mem_rd, 0);
    check_output("midrst_result", $unsigned(bus.result), 0);
    check_output("midrst_done", bus.done, 0);
    check_output("midrst_busy", bus.busy, 0);
    bus.ready_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(10);
    check_output("len10_result", $unsigned(bus.result), 16'h0DC0);
    check_output("len10_latency", lat, 13);
    check_output("len10_reads", rd_seen, 10);
    drop_ready();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
